aes_decipher_block: RTL

- Iterative AES-128 inverse cipher datapath. It is the consumer side of the round-key interface of the key-expansion block.
- It drives a 4-bit round index and reads the 128-bit round key back with zero latency, walking the rounds in reverse order, 10 down to 0.
- InvSubBytes is performed one 32-bit word per cycle through an external inverse S-box port.
- It sits in the AES core next to the key-expansion block and the shared S-box/inverse-S-box ROMs.

---
 rtl/aes_decipher_block.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/aes_decipher_block.sv
// Iterative AES-128 inverse cipher; one InvSubBytes word per cycle through an external inverse S-box.
// Optional start_err output enabled by defining AES_DEC_START_ERR_EN.
//
// state | meaning
// IDLE  | result valid, waiting for an accepted start
// INIT  | add round key 10, InvShiftRows
// SBOX  | stream the four state words through the inverse S-box
// MAIN  | add round key; InvMixColumns + InvShiftRows, or finish on round 0
module aes_decipher_block #(
  parameter int SBOX_LAT = 0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [127:0] block,
  input  logic         key_ready,
  output logic [3:0]   round,
  input  logic [127:0] round_key,
  output logic [31:0]  inv_sboxw,
  input  logic [31:0]  new_inv_sboxw,
  output logic [127:0] result,
  output logic         ready
`ifdef AES_DEC_START_ERR_EN
  ,
  output logic         start_err
`endif
);

  typedef enum logic [1:0] {IDLE, INIT, SBOX, MAIN} fsm_t;

  localparam logic [1:0] LAT_W  = 2'(SBOX_LAT);
  localparam logic [2:0] LAST_W = 3'(SBOX_LAT + 3);

  fsm_t         fsm;
  logic [127:0] data;
  logic [2:0]   w;
  logic         cap_en;
  logic [1:0]   cap_idx;

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
    logic [7:0] a  [4];
    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];
    logic [7:0] x2, x4, x8;
    for (int i = 0; i < 4; i++) begin
      a[i]  = col[31-8*i -: 8];
      x2    = xt(a[i]);
      x4    = xt(x2);
      x8    = xt(x4);
      m9[i] = x8 ^ a[i];
      mb[i] = x8 ^ x2 ^ a[i];
      md[i] = x8 ^ x4 ^ a[i];
      me[i] = x8 ^ x4 ^ x2;
    end
    return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
            m9[0] ^ me[1] ^ mb[2] ^ md[3],
            md[0] ^ m9[1] ^ me[2] ^ mb[3],
            mb[0] ^ md[1] ^ m9[2] ^ me[3]};
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    return {inv_mix_col(s[127:96]), inv_mix_col(s[95:64]),
            inv_mix_col(s[63:32]),  inv_mix_col(s[31:0])};
  endfunction

  // Row r is rotated right by r byte positions.
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-32*c-8*r -: 8] = s[127-32*((c+4-r)%4)-8*r -: 8];
    return o;
  endfunction

  function automatic logic [31:0] get_word(input logic [127:0] s, input logic [1:0] idx);
    case (idx)
      2'd0:    return s[127:96];
      2'd1:    return s[95:64];
      2'd2:    return s[63:32];
      default: return s[31:0];
    endcase
  endfunction

  function automatic logic [127:0] put_word(input logic [127:0] s, input logic [1:0] idx,
                                            input logic [31:0] v);
    logic [127:0] o;
    o = s;
    case (idx)
      2'd0:    o[127:96] = v;
      2'd1:    o[95:64]  = v;
      2'd2:    o[63:32]  = v;
      default: o[31:0]   = v;
    endcase
    return o;
  endfunction

  // With a registered ROM the word returned in cycle w belongs to word w-1.
  always_comb begin
    cap_en  = (SBOX_LAT == 0) || (w != 3'd0);
    cap_idx = w[1:0] - LAT_W;
  end

  always_comb begin
    inv_sboxw = '0;
    if (fsm == SBOX && w <= 3'd3)
      inv_sboxw = get_word(data, w[1:0]);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fsm    <= IDLE;
      data   <= '0;
      w      <= '0;
      round  <= '0;
      result <= '0;
      ready  <= 1'b1;
`ifdef AES_DEC_START_ERR_EN
      start_err <= 1'b0;
`endif
    end else begin
`ifdef AES_DEC_START_ERR_EN
      start_err <= start && !(fsm == IDLE && key_ready);
`endif
      case (fsm)
        IDLE: begin
          if (start && key_ready) begin
            data  <= block;
            round <= 4'd10;
            ready <= 1'b0;
            fsm   <= INIT;
          end
        end
        INIT: begin
          data  <= inv_shift_rows(data ^ round_key);
          round <= 4'd9;
          w     <= '0;
          fsm   <= SBOX;
        end
        SBOX: begin
          if (cap_en)
            data <= put_word(data, cap_idx, new_inv_sboxw);
          if (w == LAST_W) begin
            w   <= '0;
            fsm <= MAIN;
          end else begin
            w <= w + 3'd1;
          end
        end
        MAIN: begin
          if (round != 4'd0) begin
            data  <= inv_shift_rows(inv_mix_columns(data ^ round_key));
            round <= round - 4'd1;
            w     <= '0;
            fsm   <= SBOX;
          end else begin
            result <= data ^ round_key;
            ready  <= 1'b1;
            round  <= '0;
            fsm    <= IDLE;
          end
        end
        default: fsm <= IDLE;
      endcase
    end
  end

endmodule
